seatbelt_reminder_ctrl: RTL

Sequential controller that owns the seatbelt warning light and adds the chime sequencing around it. It synchronizes and debounces the driver-belt, passenger-belt, passenger-seat and ignition inputs, and evaluates the violation condition SBL = ~DBI | (P & ~PBI). It then steps through a grace / chime / silent-blink schedule. It sits between the raw cabin switch inputs and the dash lamp and chime drivers.

---
 rtl/seatbelt_reminder_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seatbelt_reminder_ctrl.sv
// Seatbelt lamp and chime sequencer: synchronizes and debounces cabin switches,
// then runs a grace / chime / silent-blink schedule while a violation persists.
module seatbelt_reminder_ctrl #(
    parameter int DEBOUNCE_CYC  = 4,
    parameter int GRACE_CYC     = 16,
    parameter int CHIME_ON_CYC  = 4,
    parameter int CHIME_OFF_CYC = 4,
    parameter int CHIME_BURSTS  = 3,
    parameter int BLINK_CYC     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       IGN,
    input  logic       DBI,
    input  logic       PBI,
    input  logic       P,
    output logic       SBL,
    output logic       CHIME,
    output logic [2:0] state_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = max2(max2(max2(DEBOUNCE_CYC, GRACE_CYC),
                                    max2(CHIME_ON_CYC, CHIME_OFF_CYC)),
                               max2(CHIME_BURSTS, BLINK_CYC));
    localparam int W = $clog2(MAXP + 1);

    localparam logic [W-1:0] D_LAST   = W'(DEBOUNCE_CYC - 1);
    localparam logic [W-1:0] G_LAST   = W'(GRACE_CYC - 1);
    localparam logic [W-1:0] ON_LAST  = W'(CHIME_ON_CYC - 1);
    localparam logic [W-1:0] OFF_LAST = W'(CHIME_OFF_CYC - 1);
    localparam logic [W-1:0] B_LAST   = W'(CHIME_BURSTS - 1);
    localparam logic [W-1:0] BL_LAST  = W'(BLINK_CYC - 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_MONITOR = 3'd1,
        S_GRACE   = 3'd2,
        S_CHIME   = 3'd3,
        S_SILENT  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     sync1, sync2;
    logic           ign_s, dbi_s, pbi_s, p_s;
    logic           viol_raw, viol_db;
    logic [W-1:0]   db_cnt;
    logic [W-1:0]   cnt;
    logic [W-1:0]   burst_cnt;
    logic           half;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {IGN, DBI, PBI, P};
            sync2 <= sync1;
        end
    end

    assign {ign_s, dbi_s, pbi_s, p_s} = sync2;
    assign viol_raw = ~dbi_s | (p_s & ~pbi_s);

    // viol_db flips only after DEBOUNCE_CYC consecutive disagreeing cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol_db <= 1'b0;
            db_cnt  <= '0;
        end else if (viol_raw == viol_db) begin
            db_cnt <= '0;
        end else if (db_cnt == D_LAST) begin
            viol_db <= viol_raw;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_OFF;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!ign_s) begin
            state_d = S_OFF;
        end else begin
            unique case (state_q)
                S_OFF:     state_d = S_MONITOR;
                S_MONITOR: if (viol_db) state_d = S_GRACE;
                S_GRACE: begin
                    if (!viol_db)           state_d = S_MONITOR;
                    else if (cnt == G_LAST) state_d = S_CHIME;
                end
                S_CHIME: begin
                    if (!viol_db)
                        state_d = S_MONITOR;
                    else if (half && cnt == OFF_LAST && burst_cnt == B_LAST)
                        state_d = S_SILENT;
                end
                S_SILENT:  if (!viol_db) state_d = S_MONITOR;
                default:   state_d = S_OFF;
            endcase
        end
    end

    // cnt times the current phase; half selects chime-off / blink-off phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            burst_cnt <= '0;
            half      <= 1'b0;
        end else if (state_d != state_q) begin
            cnt       <= '0;
            burst_cnt <= '0;
            half      <= 1'b0;
        end else begin
            unique case (state_q)
                S_GRACE: if (cnt != '1) cnt <= cnt + 1'b1;
                S_CHIME: begin
                    if (cnt == (half ? OFF_LAST : ON_LAST)) begin
                        cnt  <= '0;
                        half <= ~half;
                        if (half && burst_cnt != '1)
                            burst_cnt <= burst_cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SILENT: begin
                    if (cnt == BL_LAST) begin
                        cnt  <= '0;
                        half <= ~half;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        SBL   = 1'b0;
        CHIME = 1'b0;
        unique case (state_q)
            S_GRACE:  SBL = 1'b1;
            S_CHIME: begin
                SBL   = 1'b1;
                CHIME = ~half;
            end
            S_SILENT: SBL = ~half;
            default:  ;
        endcase
    end

    assign state_o = state_q;

endmodule
